// File: rtl/tlc_pkg.sv
// Shared light codes, state codes and light decode for the junction controllers.
// The state encoding is the externally visible phase code.
package tlc_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    ST_MAIN_GRN = 3'd0,
    ST_M2_YEL   = 3'd1,
    ST_TURN_GRN = 3'd2,
    ST_TURN_YEL = 3'd3,
    ST_MAIN_YEL = 3'd4,
    ST_ALL_RED  = 3'd5,
    ST_SIDE_GRN = 3'd6,
    ST_SIDE_YEL = 3'd7
  } state_e;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } lights_t;

  // M1 keeps green through the turn phase, so M1 and MT never conflict.
  function automatic lights_t decode_lights(input state_e st);
    lights_t lt;
    lt = '{m1: LT_RED, m2: LT_RED, mt: LT_RED, s: LT_RED};
    case (st)
      ST_MAIN_GRN: begin lt.m1 = LT_GRN; lt.m2 = LT_GRN; end
      ST_M2_YEL:   begin lt.m1 = LT_GRN; lt.m2 = LT_YEL; end
      ST_TURN_GRN: begin lt.m1 = LT_GRN; lt.mt = LT_GRN; end
      ST_TURN_YEL: begin lt.m1 = LT_YEL; lt.mt = LT_YEL; end
      ST_MAIN_YEL: begin lt.m1 = LT_YEL; lt.m2 = LT_YEL; end
      ST_ALL_RED:  lt = lt;
      ST_SIDE_GRN: lt.s = LT_GRN;
      ST_SIDE_YEL: lt.s = LT_YEL;
      default:     lt = lt;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/junction_phase_scheduler_if.sv
// Request inputs and light outputs of the junction phase scheduler.
// master = request/observer side, slave = scheduler.
interface junction_phase_scheduler_if;

  logic       req_side;
  logic       req_turn;
  logic       emerg;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic [2:0] phase;
  logic       preempt_active;

  modport master (
    output req_side, req_turn, emerg,
    input  light_M1, light_M2, light_MT, light_S, phase, preempt_active
  );

  modport slave (
    input  req_side, req_turn, emerg,
    output light_M1, light_M2, light_MT, light_S, phase, preempt_active
  );

endinterface

// File: rtl/junction_phase_scheduler_phase_timer.sv
// Shared phase dwell down-counter: load on state entry, count to zero and hold there.
// expire_o is high while the count is zero; load_i takes priority over counting.
module phase_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expire_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/junction_phase_scheduler.sv
// Demand-driven phase sequencer for a four-approach junction (1 cycle = 1 s tick).
// Optional emergency preemption is built when EMERG_PREEMPT_EN is defined.
module junction_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int T_MAIN = 7,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int T_YEL  = 2,
  parameter int T_CLR  = 1,
  parameter int TW     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  junction_phase_scheduler_if.slave   bus
);

  state_e        state_q;
  state_e        state_d;
  logic          side_pend_q;
  logic          side_pend_d;
  logic          turn_pend_q;
  logic          turn_pend_d;
  logic          expire;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          emerg_act;
  lights_t       lights;

  function automatic logic [TW-1:0] dwell_m1(input state_e st);
    int d;
    case (st)
      ST_MAIN_GRN: d = T_MAIN;
      ST_TURN_GRN: d = T_TURN;
      ST_SIDE_GRN: d = T_SIDE;
      ST_ALL_RED:  d = T_CLR;
      default:     d = T_YEL;
    endcase
    return TW'(d - 1);
  endfunction

`ifdef EMERG_PREEMPT_EN
  assign emerg_act = bus.emerg;
`else
  logic unused_emerg;
  assign unused_emerg = bus.emerg;
  assign emerg_act    = 1'b0;
`endif

  // Turn outranks side; preemption only ever shortens greens or steers back to main.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_GRN: begin
        if (expire && !emerg_act) begin
          if (turn_pend_q) begin
            state_d = ST_M2_YEL;
          end else if (side_pend_q) begin
            state_d = ST_MAIN_YEL;
          end
        end
      end
      ST_M2_YEL:   if (expire) state_d = emerg_act ? ST_MAIN_YEL : ST_TURN_GRN;
      ST_TURN_GRN: if (expire || emerg_act) state_d = ST_TURN_YEL;
      ST_TURN_YEL: if (expire) state_d = ST_ALL_RED;
      ST_MAIN_YEL: if (expire) state_d = ST_ALL_RED;
      ST_ALL_RED: begin
        if (expire) begin
          state_d = (side_pend_q && !emerg_act) ? ST_SIDE_GRN : ST_MAIN_GRN;
        end
      end
      ST_SIDE_GRN: if (expire || emerg_act) state_d = ST_SIDE_YEL;
      ST_SIDE_YEL: if (expire) state_d = ST_ALL_RED;
      default:     state_d = ST_MAIN_GRN;
    endcase
  end

  // A request arriving on the serving edge survives, so the phase is owed again.
  always_comb begin
    side_pend_d = bus.req_side |
                  (side_pend_q & ~((state_d == ST_SIDE_GRN) && (state_q != ST_SIDE_GRN)));
    turn_pend_d = bus.req_turn |
                  (turn_pend_q & ~((state_d == ST_TURN_GRN) && (state_q != ST_TURN_GRN)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_MAIN_GRN;
      side_pend_q <= 1'b0;
      turn_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_pend_q <= side_pend_d;
      turn_pend_q <= turn_pend_d;
    end
  end

  // No state ever transitions to itself, so a state change marks phase entry.
  assign tmr_load     = (state_d != state_q);
  assign tmr_load_val = dwell_m1(state_d);

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(T_MAIN - 1))
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expire_o   (expire)
  );

  assign lights             = decode_lights(state_q);
  assign bus.light_M1       = lights.m1;
  assign bus.light_M2       = lights.m2;
  assign bus.light_MT       = lights.mt;
  assign bus.light_S        = lights.s;
  assign bus.phase          = state_q;
  assign bus.preempt_active = emerg_act & rst;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed bench for junction_phase_scheduler; expected phase sequences are hand-derived.
module tb_junction_phase_scheduler;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  junction_phase_scheduler_if bus_if ();

  junction_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  // {M1,M2,MT,S} per phase code, straight from the phase table.
  function automatic logic [11:0] exp_lights(input int ph);
    case (ph)
      0:       return 12'b001_001_100_100;
      1:       return 12'b001_010_100_100;
      2:       return 12'b001_100_001_100;
      3:       return 12'b010_100_010_100;
      4:       return 12'b010_010_100_100;
      5:       return 12'b100_100_100_100;
      6:       return 12'b100_100_100_001;
      default: return 12'b100_100_100_010;
    endcase
  endfunction

  task automatic check_now(input int ph);
    logic ep;
`ifdef EMERG_PREEMPT_EN
    ep = bus_if.emerg;
`else
    ep = 1'b0;
`endif
    chk("phase", 32'(bus_if.phase), 32'(ph));
    chk("lights", 32'({bus_if.light_M1, bus_if.light_M2, bus_if.light_MT, bus_if.light_S}),
        32'(exp_lights(ph)));
    chk("preempt", 32'(bus_if.preempt_active), 32'(ep));
  endtask

  task automatic run(input int ph, input int n);
    for (int i = 0; i < n; i++) begin
      check_now(ph);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus_if.req_side = 1'b0;
    bus_if.req_turn = 1'b0;
    bus_if.emerg    = 1'b0;
    @(posedge clk);
    #1;
    check_now(0);
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Idle: main green forever.
    do_reset();
    run(0, 30);

    // Side pulse late in main green.
    do_reset();
    run(0, 10);
    bus_if.req_side = 1'b1;
    run(0, 1);
    bus_if.req_side = 1'b0;
    run(0, 1);
    run(4, 2); run(5, 1); run(6, 3); run(7, 2); run(5, 1);
    run(0, 10);

    // Side pulse early: minimum main green still honoured.
    do_reset();
    run(0, 2);
    bus_if.req_side = 1'b1;
    run(0, 1);
    bus_if.req_side = 1'b0;
    run(0, 4);
    run(4, 2); run(5, 1); run(6, 3); run(7, 2); run(5, 1);
    run(0, 3);

    // Turn and side together: turn first, then side without main in between.
    do_reset();
    run(0, 10);
    bus_if.req_side = 1'b1;
    bus_if.req_turn = 1'b1;
    run(0, 1);
    bus_if.req_side = 1'b0;
    bus_if.req_turn = 1'b0;
    run(0, 1);
    run(1, 2); run(2, 5); run(3, 2); run(5, 1); run(6, 3); run(7, 2); run(5, 1);
    run(0, 9);

    // Emergency on the 2nd cycle of side green.
    do_reset();
    run(0, 2);
    bus_if.req_side = 1'b1;
    run(0, 1);
    bus_if.req_side = 1'b0;
    run(0, 4);
    run(4, 2); run(5, 1); run(6, 1);
    bus_if.emerg = 1'b1;
`ifdef EMERG_PREEMPT_EN
    run(6, 1); run(7, 2); run(5, 1);
    run(0, 2);
    bus_if.req_side = 1'b1;
    run(0, 1);
    bus_if.req_side = 1'b0;
    run(0, 9);
    bus_if.emerg = 1'b0;
    run(0, 1);
    run(4, 2);
`else
    run(6, 2); run(7, 2); run(5, 1);
    bus_if.emerg = 1'b0;
    run(0, 3);
`endif

    // Reset during turn green with side owed: immediate abort, no side later.
    do_reset();
    run(0, 10);
    bus_if.req_side = 1'b1;
    bus_if.req_turn = 1'b1;
    run(0, 1);
    bus_if.req_side = 1'b0;
    bus_if.req_turn = 1'b0;
    run(0, 1);
    run(1, 2); run(2, 2);
    rst = 1'b0;
    #1;
    check_now(0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
